// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size codes, load FSM encoding and split rule for the LSU load path.
package lsu_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ1  = 3'd1;
  localparam logic [2:0] WAIT1 = 3'd2;
  localparam logic [2:0] REQ2  = 3'd3;
  localparam logic [2:0] WAIT2 = 3'd4;
  // size 2'b11 behaves as a word, so size[1] alone marks a word access
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    return (size[1] && offset != 2'd0) || (size == SZ_HALF && offset == 2'd3);
  endfunction
endpackage

// File: rtl/load_extend.sv
// load_extend: shifts the {hi, lo} word pair by the byte offset and sign/zero-extends the result.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);
  logic [31:0] sh;
  assign sh = 32'({hi, lo} >> {offset, 3'b000});
  always_comb begin
    result = size[1] ? sh :
             size == SZ_HALF ? {{16{~is_unsigned & sh[15]}}, sh[15:0]} :
                               {{24{~is_unsigned & sh[7]}}, sh[7:0]};
  end
endmodule

// File: rtl/load_aligner.sv
// load_aligner: issues one or two word-aligned reads per load and delivers the extended result.
module load_aligner
  import lsu_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [1:0]    ld_size,
  input  logic          ld_unsigned,
  input  logic [AW-1:0] ld_addr,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata,
  output logic          data_valid,
  output logic [31:0]   data_out,
  output logic          misaligned
);
  logic [2:0]  state;
  logic [1:0]  off;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] lo;
  logic [31:0] ext;
  logic        accept;
  logic        fin;
  assign ld_ready = state == IDLE;
  assign mem_be   = 4'hF;
  assign accept   = ld_valid && ld_ready;
  assign fin      = mem_rvalid && (state == WAIT2 || (state == WAIT1 && !misaligned));
  // the result is formed in the same cycle as the final rvalid, straight from the bus
  load_extend u_ext (
    .lo          (state == WAIT1 ? mem_rdata : lo),
    .hi          (state == WAIT2 ? mem_rdata : 32'h0),
    .offset      (off),
    .size        (size),
    .is_unsigned (uns),
    .result      (ext)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      off        <= 2'd0;
      size       <= SZ_BYTE;
      uns        <= 1'b0;
      lo         <= 32'h0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      data_valid <= 1'b0;
      data_out   <= 32'h0;
      misaligned <= 1'b0;
    end else begin
      data_valid <= fin;
      if (fin) data_out <= ext;
      if (accept) begin
        state      <= REQ1;
        mem_req    <= 1'b1;
        mem_addr   <= {ld_addr[AW-1:2], 2'b00};
        off        <= ld_addr[1:0];
        size       <= ld_size;
        uns        <= ld_unsigned;
        misaligned <= is_misaligned(ld_size, ld_addr[1:0]);
      end else if ((state == REQ1 || state == REQ2) && mem_gnt) begin
        state   <= state == REQ1 ? WAIT1 : WAIT2;
        mem_req <= 1'b0;
      end else if (state == WAIT1 && mem_rvalid) begin
        lo      <= mem_rdata;
        state   <= misaligned ? REQ2 : IDLE;
        mem_req <= misaligned;
        if (misaligned) mem_addr <= mem_addr + AW'(4);
      end else if (state == WAIT2 && mem_rvalid) begin
        state <= IDLE;
      end
    end
  end
endmodule
